pixel_scanout_buffer: RTL and testbench

PIXEL_SCANOUT_BUFFER -- requirements
Module: pixel_scanout_buffer

---
 rtl/pixel_scanout_buffer_pkg.sv | 21 ++
 rtl/pixel_scanout_buffer_if.sv | 39 +++
 rtl/pixel_bank_ram.sv | 26 ++
 rtl/pixel_scanout_buffer.sv | 128 ++++++++++++
 tb/tb_pixel_scanout_buffer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_scanout_buffer_pkg.sv
// Shared constants and helpers for the pixel scanout line buffer.
package pixel_scanout_buffer_pkg;

  localparam logic [15:0] RGB565_BLACK       = 16'h0000;
  localparam int          BANK_WORDS_DEFAULT = 512;
  localparam int          MAX_WIDTH_DEFAULT  = 640;
  localparam logic [9:0]  CNT_MAX            = 10'd1023;

  // Sideband that travels alongside the RAM read.
  typedef struct packed {
    logic       valid;
    logic       gray;
    logic [1:0] lane;
    logic       blank;
  } rd_tag_t;

  function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

// File: rtl/pixel_scanout_buffer_if.sv
// Configuration, DMA, video-timing and pixel-output signals of the scanout buffer.
interface pixel_scanout_buffer_if
  import pixel_scanout_buffer_pkg::*;
#(
  parameter int BANK_WORDS = BANK_WORDS_DEFAULT
);
  localparam int AW = $clog2(BANK_WORDS);

  logic [9:0]    graphicsWidth;
  logic [9:0]    graphicsHeight;
  logic          dualPixel;
  logic          grayscale;
  logic          bufferWe;
  logic [AW-1:0] bufferAddress;
  logic [31:0]   bufferData;
  logic          writeIndex;
  logic          frameStartIn;
  logic          lineStartIn;
  logic          pixelRequest;
  logic          newScreen;
  logic          newLine;
  logic          pixelValid;
  logic [15:0]   pixelData;

  modport master (
    output graphicsWidth, graphicsHeight, dualPixel, grayscale,
    output bufferWe, bufferAddress, bufferData, writeIndex,
    output frameStartIn, lineStartIn, pixelRequest,
    input  newScreen, newLine, pixelValid, pixelData
  );

  modport slave (
    input  graphicsWidth, graphicsHeight, dualPixel, grayscale,
    input  bufferWe, bufferAddress, bufferData, writeIndex,
    input  frameStartIn, lineStartIn, pixelRequest,
    output newScreen, newLine, pixelValid, pixelData
  );

endinterface

// File: rtl/pixel_bank_ram.sv
// Two line banks in one simple dual-port RAM; the bank select is the address MSB.
module pixel_bank_ram #(
  parameter int BANK_WORDS = 512,
  parameter int AW         = $clog2(BANK_WORDS) + 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2*BANK_WORDS];
  logic [31:0] r_rdata;

  // No reset on purpose: contents survive reset. Non-blocking update gives read-first.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_scanout_buffer.sv
// Double-banked line buffer: DMA fills one bank while the other is unpacked to RGB565.
module pixel_scanout_buffer
  import pixel_scanout_buffer_pkg::*;
#(
  parameter int BANK_WORDS = BANK_WORDS_DEFAULT,
  parameter int MAX_WIDTH  = MAX_WIDTH_DEFAULT
) (
  input logic                    clock,
  input logic                    reset,
  pixel_scanout_buffer_if.slave  bus
);

  localparam int          AW    = $clog2(BANK_WORDS);
  localparam logic [10:0] MAX_W = 11'(MAX_WIDTH);

  logic [9:0]  r_line_cnt;
  logic [9:0]  r_line_idx;
  logic [9:0]  r_x;
  logic [9:0]  r_width;
  logic        r_dual;
  logic        r_gray;
  logic        r_bank;
  logic        r_new_screen;
  logic        r_new_line;
  rd_tag_t     r_s1;
  logic        r_valid;
  logic [15:0] r_data;

  logic          w_ls;
  logic [9:0]    w_cnt_base;
  logic [9:0]    w_width;
  logic          w_dual;
  logic          w_gray;
  logic          w_bank;
  logic [9:0]    w_x;
  logic [9:0]    w_line_idx;
  logic [9:0]    w_p;
  logic [9:0]    w_word;
  logic [1:0]    w_lane;
  logic          w_blank;
  logic [AW:0]   w_raddr;
  logic [AW:0]   w_waddr;
  logic [31:0]   w_rdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_pix;

  // A request in the same cycle as lineStartIn already sees the new line's settings.
  assign w_ls       = bus.lineStartIn;
  assign w_cnt_base = bus.frameStartIn ? 10'd0 : r_line_cnt;
  assign w_width    = w_ls ? bus.graphicsWidth : r_width;
  assign w_dual     = w_ls ? bus.dualPixel     : r_dual;
  assign w_gray     = w_ls ? bus.grayscale     : r_gray;
  assign w_bank     = w_ls ? ~bus.writeIndex   : r_bank;
  assign w_x        = w_ls ? 10'd0             : r_x;
  assign w_line_idx = w_ls ? w_cnt_base        : r_line_idx;

  assign w_p     = w_dual ? {1'b0, w_x[9:1]} : w_x;
  assign w_word  = w_gray ? {2'b0, w_p[9:2]} : {1'b0, w_p[9:1]};
  assign w_lane  = w_gray ? w_p[1:0] : {1'b0, w_p[0]};
  assign w_blank = (w_x >= w_width) || ({1'b0, w_x} >= MAX_W) ||
                   (w_line_idx >= bus.graphicsHeight);

  assign w_raddr = {w_bank, AW'(w_word)};
  assign w_waddr = {bus.writeIndex, bus.bufferAddress};

  pixel_bank_ram #(
    .BANK_WORDS (BANK_WORDS)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (bus.bufferWe),
    .i_waddr (w_waddr),
    .i_wdata (bus.bufferData),
    .i_re    (bus.pixelRequest),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_byte = w_rdata[7:0];
    case (r_s1.lane)
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
    w_pix = r_s1.gray ? gray_to_rgb565(w_byte)
                      : (r_s1.lane[0] ? w_rdata[31:16] : w_rdata[15:0]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line_cnt   <= '0;
      r_line_idx   <= '0;
      r_x          <= '0;
      r_width      <= '0;
      r_dual       <= 1'b0;
      r_gray       <= 1'b0;
      r_bank       <= 1'b0;
      r_new_screen <= 1'b0;
      r_new_line   <= 1'b0;
      r_s1         <= '0;
      r_valid      <= 1'b0;
      r_data       <= RGB565_BLACK;
    end else begin
      r_new_screen <= bus.frameStartIn;
      r_new_line   <= w_ls && (w_cnt_base < bus.graphicsHeight);
      r_line_cnt   <= (w_ls && (w_cnt_base != CNT_MAX)) ? w_cnt_base + 10'd1 : w_cnt_base;
      if (w_ls) begin
        r_line_idx <= w_cnt_base;
        r_width    <= bus.graphicsWidth;
        r_dual     <= bus.dualPixel;
        r_gray     <= bus.grayscale;
        r_bank     <= ~bus.writeIndex;
      end
      r_x     <= (bus.pixelRequest && (w_x != CNT_MAX)) ? w_x + 10'd1 : w_x;
      r_s1    <= '{valid: bus.pixelRequest, gray: w_gray, lane: w_lane, blank: w_blank};
      r_valid <= r_s1.valid;
      if (!r_s1.valid || r_s1.blank) r_data <= RGB565_BLACK;
      else                           r_data <= w_pix;
    end
  end

  assign bus.newScreen  = r_new_screen;
  assign bus.newLine    = r_new_line;
  assign bus.pixelValid = r_valid;
  assign bus.pixelData  = r_data;

endmodule

// File: tb/tb_pixel_scanout_buffer.sv
// Randomized and directed bench for pixel_scanout_buffer against a line-level reference model.
module tb_pixel_scanout_buffer;

  localparam int BW   = 512;
  localparam int MAXW = 640;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_scanout_buffer_if #(.BANK_WORDS(BW)) bus ();

  pixel_scanout_buffer #(
    .BANK_WORDS (BW),
    .MAX_WIDTH  (MAXW)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit [31:0] m_mem [2][BW];
  int        m_cnt, m_idx, m_x, m_width;
  bit        m_dual, m_gray, m_bank;
  bit        m_v1, m_v2, m_ns, m_nl;
  bit [15:0] m_d1, m_d2;

  logic [15:0] got[$];
  int          n_ns, n_nl;

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_x = 0; m_width = 0;
    m_dual = 0; m_gray = 0; m_bank = 0;
    m_v1 = 0; m_v2 = 0; m_ns = 0; m_nl = 0; m_d1 = 0; m_d2 = 0;
  endtask

  function automatic bit [15:0] model_pixel(input int x, input int height);
    int p, g;
    bit [31:0] w;
    if (x >= m_width || x >= MAXW || m_idx >= height) return 16'h0000;
    p = m_dual ? x / 2 : x;
    if (m_gray) begin
      w = m_mem[m_bank][p / 4];
      g = int'((w >> (8 * (p % 4))) & 32'hFF);
      return 16'(((g >> 3) << 11) | ((g >> 2) << 5) | (g >> 3));
    end
    w = m_mem[m_bank][p / 2];
    return 16'((w >> (16 * (p % 2))) & 32'hFFFF);
  endfunction

  task automatic model_step();
    int base, height;
    height = int'(bus.graphicsHeight);
    base   = bus.frameStartIn ? 0 : m_cnt;
    m_ns   = bus.frameStartIn;
    m_nl   = bus.lineStartIn && (base < height);
    if (bus.lineStartIn) begin
      m_idx   = base;
      m_width = int'(bus.graphicsWidth);
      m_dual  = bus.dualPixel;
      m_gray  = bus.grayscale;
      m_bank  = !bus.writeIndex;
      m_x     = 0;
    end
    m_cnt = (bus.lineStartIn && base < 1023) ? base + 1 : base;
    m_v2 = m_v1;
    m_d2 = m_d1;
    m_v1 = bus.pixelRequest;
    m_d1 = 16'h0000;
    if (bus.pixelRequest) begin
      m_d1 = model_pixel(m_x, height);
      if (m_x < 1023) m_x++;
    end
    if (bus.bufferWe) m_mem[bus.writeIndex][bus.bufferAddress] = bus.bufferData;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pixelValid", 32'(bus.pixelValid), 32'(m_v2));
    chk("pixelData",  32'(bus.pixelData),  32'(m_v2 ? m_d2 : 16'h0000));
    chk("newScreen",  32'(bus.newScreen),  32'(m_ns));
    chk("newLine",    32'(bus.newLine),    32'(m_nl));
    if (bus.pixelValid) got.push_back(bus.pixelData);
    n_ns += int'(bus.newScreen);
    n_nl += int'(bus.newLine);
  endtask

  task automatic cyc(input bit fs, input bit ls, input bit req);
    bus.frameStartIn = fs;
    bus.lineStartIn  = ls;
    bus.pixelRequest = req;
    tick();
    bus.frameStartIn = 1'b0;
    bus.lineStartIn  = 1'b0;
    bus.pixelRequest = 1'b0;
    bus.bufferWe     = 1'b0;
  endtask

  task automatic dma(input bit idx, input int addr, input logic [31:0] data);
    bus.writeIndex    = idx;
    bus.bufferAddress = 9'(addr);
    bus.bufferData    = data;
    bus.bufferWe      = 1'b1;
    cyc(0, 0, 0);
  endtask

  task automatic set_mode(input int width, input int height, input bit gray, input bit dual);
    bus.graphicsWidth  = 10'(width);
    bus.graphicsHeight = 10'(height);
    bus.grayscale      = gray;
    bus.dualPixel      = dual;
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp39 [2];
    logic [15:0] exp40 [8];
    logic [15:0] exp41 [6];
    int len;

    exp39 = '{16'hABCD, 16'h1234};
    exp40 = '{16'h0000, 16'h0000, 16'h4208, 16'h4208, 16'hFFFF, 16'hFFFF, 16'h8410, 16'h8410};
    exp41 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'h0000};

    set_mode(0, 0, 0, 0);
    bus.bufferWe = 0; bus.bufferAddress = '0; bus.bufferData = '0; bus.writeIndex = 0;
    bus.frameStartIn = 0; bus.lineStartIn = 0; bus.pixelRequest = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid",  32'(bus.pixelValid), 32'd0);
    chk("rst_data",   32'(bus.pixelData),  32'd0);
    chk("rst_screen", 32'(bus.newScreen),  32'd0);
    chk("rst_line",   32'(bus.newLine),    32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < BW; a++)
      for (int b = 0; b < 2; b++) dma(b[0], a, $urandom);

    // RGB565 basic unpack
    dma(0, 0, 32'h1234ABCD);
    bus.writeIndex = 1;
    set_mode(640, 10, 0, 0);
    cyc(0, 1, 0);
    got.delete();
    cyc(0, 0, 1); cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    chk("rgb_count", 32'(got.size()), 32'd2);
    for (int i = 0; i < 2; i++) chk("rgb_px", got_at(i), 32'(exp39[i]));

    // Gray with dual pixel
    dma(1, 0, 32'h80FF4000);
    bus.writeIndex = 0;
    set_mode(16, 10, 1, 1);
    cyc(0, 1, 0);
    got.delete();
    repeat (8) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    chk("gray_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("gray_px", got_at(i), 32'(exp40[i]));

    // Width limit blanks the tail
    dma(0, 0, 32'h22221111);
    dma(0, 1, 32'h44443333);
    dma(0, 2, 32'h66665555);
    bus.writeIndex = 1;
    set_mode(4, 10, 0, 0);
    cyc(0, 1, 0);
    got.delete();
    repeat (6) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    chk("width_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("width_px", got_at(i), 32'(exp41[i]));

    // Height limit: third line of a two-line frame is black
    set_mode(640, 2, 0, 0);
    n_ns = 0; n_nl = 0;
    cyc(1, 0, 0);
    for (int l = 0; l < 3; l++) begin
      got.delete();
      cyc(0, 1, 0);
      repeat (4) cyc(0, 0, 1);
      repeat (3) cyc(0, 0, 0);
    end
    chk("height_screens", 32'(n_ns), 32'd1);
    chk("height_lines",   32'(n_nl), 32'd2);
    chk("height_count",   32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("height_black", got_at(i), 32'd0);

    // Frame and line start together count that line as line 0
    set_mode(640, 1, 0, 0);
    cyc(1, 1, 0);
    chk("coinc_screen", 32'(bus.newScreen), 32'd1);
    chk("coinc_line",   32'(bus.newLine),   32'd1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("coinc_next_line", 32'(bus.newLine), 32'd0);

    // Randomized lines with concurrent DMA traffic
    for (int it = 0; it < 60; it++) begin
      set_mode(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 64)),
               int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom));
      bus.writeIndex = 1'($urandom);
      len = int'($urandom_range(8, 60));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.bufferWe      = 1'b1;
          bus.writeIndex    = 1'($urandom);
          bus.bufferAddress = 9'($urandom_range(0, 31));
          bus.bufferData    = $urandom;
        end
        cyc((c == 0) && ($urandom_range(0, 5) == 0), c == 0, $urandom_range(0, 3) != 0);
      end
    end

    // Long line crosses the maximum width
    set_mode(1023, 1023, 0, 0);
    cyc(1, 1, 0);
    repeat (700) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);

    // Line counter saturation
    cyc(1, 0, 0);
    repeat (1030) cyc(0, 1, 0);
    chk("sat_no_line", 32'(bus.newLine), 32'd0);
    repeat (4) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);

    // Reset mid-line aborts the pipeline
    set_mode(640, 10, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    bus.pixelRequest = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.pixelValid), 32'd0);
    chk("abort_data",  32'(bus.pixelData),  32'd0);
    bus.pixelRequest = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", 32'(bus.pixelValid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    got.delete();
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    chk("post_rst_count", 32'(got.size()), 32'd1);
    chk("post_rst_px",    got_at(0),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
